// File: rtl/spi_target.sv
// ---------------------------------------------------------------------------
// spi_target
// SPI mode-0 (CPOL=0, CPHA=0) target. It moves 8-bit bytes MSB first in both
// directions. All SPI pins are asynchronous: they are synchronised into clk
// and then edge-detected. The core sees a byte-wide handshake on each side.
//
// Parameters
//   SYNC_STAGES  flop stages on each SPI input (minimum 2)
//   FILL_BYTE    byte shifted out when no transmit data is offered
//
// Ports
//   clk, rst_n              system clock, synchronous active-low reset
//   spi_clk/cs_n/mosi       SPI inputs from the controller (asynchronous)
//   spi_miso                registered serial output
//   spi_miso_oe             output enable, only with SPI_TARGET_OE_EN
//   data_tx, tx_valid       next byte to send / byte is valid
//   tx_ack                  pulse: data_tx captured this cycle
//   data_rx, rx_valid       last received byte / pulse when it updates
//   busy                    synchronised chip select is asserted
//
// Build option
//   SPI_TARGET_OE_EN        adds spi_miso_oe; spi_miso then keeps tx_buf[7]
//                           after chip select is released, and the top level
//                           is expected to tristate the pad.
// ---------------------------------------------------------------------------
module spi_target #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_clk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
`ifdef SPI_TARGET_OE_EN
    output logic       spi_miso_oe,
`endif
    input  logic [7:0] data_tx,
    input  logic       tx_valid,
    output logic       tx_ack,
    output logic [7:0] data_rx,
    output logic       rx_valid,
    output logic       busy
);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    // Identical synchroniser chains keep mosi aligned with the clk edge
    // that samples it.
    logic [SYNC_STAGES-1:0] clk_chain_reg;
    logic [SYNC_STAGES-1:0] cs_chain_reg;
    logic [SYNC_STAGES-1:0] mosi_chain_reg;
    logic                   clk_prev_reg;
    logic                   cs_prev_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_chain_reg  <= '0;
            cs_chain_reg   <= '1;
            mosi_chain_reg <= '0;
            clk_prev_reg   <= 1'b0;
            cs_prev_reg    <= 1'b1;
        end else begin
            clk_chain_reg  <= {clk_chain_reg[SYNC_STAGES-2:0], spi_clk};
            cs_chain_reg   <= {cs_chain_reg[SYNC_STAGES-2:0], spi_cs_n};
            mosi_chain_reg <= {mosi_chain_reg[SYNC_STAGES-2:0], spi_mosi};
            clk_prev_reg   <= clk_chain_reg[SYNC_STAGES-1];
            cs_prev_reg    <= cs_chain_reg[SYNC_STAGES-1];
        end
    end

    logic clk_sync, cs_sync, mosi_sync;
    logic clk_rise, clk_fall, cs_fall, cs_rise;

    assign clk_sync  = clk_chain_reg[SYNC_STAGES-1];
    assign cs_sync   = cs_chain_reg[SYNC_STAGES-1];
    assign mosi_sync = mosi_chain_reg[SYNC_STAGES-1];
    assign clk_rise  =  clk_sync & ~clk_prev_reg;
    assign clk_fall  = ~clk_sync &  clk_prev_reg;
    assign cs_fall   = ~cs_sync  &  cs_prev_reg;
    assign cs_rise   =  cs_sync  & ~cs_prev_reg;

    state_t     state_reg,    state_next;
    logic [2:0] bit_cnt_reg,  bit_cnt_next;
    logic [7:0] rx_shift_reg, rx_shift_next;
    logic [7:0] tx_buf_reg,   tx_buf_next;
    logic [7:0] data_rx_reg,  data_rx_next;
    logic       rx_valid_reg, rx_valid_next;
    logic       miso_reg,     miso_next;
    logic       load;
    logic [7:0] load_byte;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= '0;
            rx_shift_reg <= '0;
            tx_buf_reg   <= '0;
            data_rx_reg  <= '0;
            rx_valid_reg <= 1'b0;
            miso_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            rx_shift_reg <= rx_shift_next;
            tx_buf_reg   <= tx_buf_next;
            data_rx_reg  <= data_rx_next;
            rx_valid_reg <= rx_valid_next;
            miso_reg     <= miso_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        rx_shift_next = rx_shift_reg;
        tx_buf_next   = tx_buf_reg;
        data_rx_next  = data_rx_reg;
        rx_valid_next = 1'b0;
        miso_next     = miso_reg;
        load          = 1'b0;
        load_byte     = tx_valid ? data_tx : FILL_BYTE;

        case (state_reg)
            ST_IDLE: begin
`ifndef SPI_TARGET_OE_EN
                miso_next = 1'b0;
`endif
                if (cs_fall) begin
                    state_next   = ST_ACTIVE;
                    bit_cnt_next = '0;
                    load         = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // cs_rise has priority: a coincident spi_clk edge is dropped
                // and any partial byte is abandoned.
                if (cs_rise) begin
                    state_next   = ST_IDLE;
                    bit_cnt_next = '0;
`ifndef SPI_TARGET_OE_EN
                    miso_next    = 1'b0;
`endif
                end else if (clk_rise) begin
                    rx_shift_next = {rx_shift_reg[6:0], mosi_sync};
                    bit_cnt_next  = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        data_rx_next  = {rx_shift_reg[6:0], mosi_sync};
                        rx_valid_next = 1'b1;
                    end
                end else if (clk_fall) begin
                    // bit_cnt is already 1 on the first falling edge, so the
                    // byte loaded at cs_fall is not reloaded here.
                    if (bit_cnt_reg != 3'd0) begin
                        tx_buf_next = {tx_buf_reg[6:0], 1'b0};
                        miso_next   = tx_buf_reg[6];
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (load) begin
            tx_buf_next = load_byte;
            miso_next   = load_byte[7];
        end
    end

    assign tx_ack   = rst_n & load & tx_valid;
    assign data_rx  = data_rx_reg;
    assign rx_valid = rx_valid_reg;
    assign spi_miso = miso_reg;
    assign busy     = ~cs_sync;
`ifdef SPI_TARGET_OE_EN
    assign spi_miso_oe = ~cs_sync;
`endif

endmodule

// File: tb/tb_spi_target.sv
// ---------------------------------------------------------------------------
// tb_spi_target
// Directed bench for spi_target: the bench plays the SPI controller and the
// core. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_spi_target;

    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_clk, spi_cs_n, spi_mosi, spi_miso;
    logic [7:0] data_tx;
    logic       tx_valid, tx_ack;
    logic [7:0] data_rx;
    logic       rx_valid, busy;
`ifdef SPI_TARGET_OE_EN
    logic       spi_miso_oe;
`endif

    spi_target #(.SYNC_STAGES(SYNC_STAGES), .FILL_BYTE(8'hFF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_clk  (spi_clk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
`ifdef SPI_TARGET_OE_EN
        .spi_miso_oe (spi_miso_oe),
`endif
        .data_tx  (data_tx),
        .tx_valid (tx_valid),
        .tx_ack   (tx_ack),
        .data_rx  (data_rx),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int half   = 6;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int         ack_cnt   = 0;
    int         idle_viol = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Core model: present tx_q, pop on tx_ack, log received bytes.
    initial begin
        logic a, r;
        logic [7:0] d;
        tx_valid = 1'b0;
        data_tx  = 8'h00;
        forever begin
            @(negedge clk);
            a = tx_ack;
            r = rx_valid;
            d = data_rx;
            if ((a || r) && !busy) idle_viol++;
            if (r) rx_q.push_back(d);
            @(posedge clk);
            #1;
            if (a) begin
                ack_cnt++;
                if (tx_q.size() > 0) void'(tx_q.pop_front());
            end
            tx_valid = (tx_q.size() > 0);
            data_tx  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        end
    end

    task automatic cs_low();
        spi_cs_n = 1'b0;
        wait_clks(half);
    endtask

    task automatic cs_high();
        wait_clks(half);
        spi_cs_n = 1'b1;
        wait_clks(2 * half);
    endtask

    // Shift nbits (MSB first) out of mo; collect miso into mi.
    task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = mo[i];
            wait_clks(half);
            mi[i]   = spi_miso;
            spi_clk = 1'b1;
            wait_clks(half);
            spi_clk = 1'b0;
        end
    endtask

    task automatic single_txn(input string name, input logic [7:0] mo, input logic [7:0] tx,
                              input logic tx_en, input logic [7:0] rx_exp, input logic [7:0] miso_exp);
        logic [7:0] mi;
        int         acks0;
        rx_q.delete();
        if (tx_en) tx_q.push_back(tx);
        wait_clks(2);
        acks0 = ack_cnt;
        cs_low();
        check({name, "_busy"}, busy, 1'b1);
        spi_bits(mo, 8, mi);
        cs_high();
        $display("txn %s: mosi=%h miso=%h rx_count=%0d acks=%0d", name, mo, mi, rx_q.size(), ack_cnt - acks0);
        check({name, "_miso"}, mi, miso_exp);
        check({name, "_acks"}, ack_cnt - acks0, tx_en ? 1 : 0);
        check({name, "_rx_count"}, rx_q.size(), 1);
        if (rx_q.size() > 0) check({name, "_rx_data"}, rx_q[0], rx_exp);
        check({name, "_busy_after"}, busy, 1'b0);
        check({name, "_miso_idle"}, spi_miso, 1'b0);
    endtask

    initial begin
        logic [7:0] mi, mi2;
        int         acks0, rx0;

        rst_n    = 1'b0;
        spi_clk  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        wait_clks(4);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_data_rx", data_rx, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_ack", tx_ack, 1'b0);
        rst_n = 1'b1;
        wait_clks(4);

        // Single byte
        single_txn("single", 8'h3C, 8'hA5, 1'b1, 8'h3C, 8'hA5);

        // Back-to-back without releasing chip select
        rx_q.delete();
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        wait_clks(2);
        acks0 = ack_cnt;
        cs_low();
        spi_bits(8'h01, 8, mi);
        spi_bits(8'h80, 8, mi2);
        cs_high();
        $display("txn b2b: mosi=01,80 miso=%h,%h rx_count=%0d acks=%0d", mi, mi2, rx_q.size(), ack_cnt - acks0);
        check("b2b_miso0", mi, 8'h11);
        check("b2b_miso1", mi2, 8'h22);
        check("b2b_acks", ack_cnt - acks0, 2);
        check("b2b_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("b2b_rx0", rx_q[0], 8'h01);
            check("b2b_rx1", rx_q[1], 8'h80);
        end

        // Underrun: fill byte goes out, receive still works
        single_txn("underrun", 8'hC3, 8'h00, 1'b0, 8'hC3, 8'hFF);

        // Abort after 5 bits, then a clean byte
        rx_q.delete();
        acks0 = ack_cnt;
        cs_low();
        spi_bits(8'hE7, 5, mi);
        cs_high();
        $display("txn abort: 5 bits, rx_count=%0d", rx_q.size());
        check("abort_rx_count", rx_q.size(), 0);
        check("abort_busy", busy, 1'b0);
        check("abort_acks", ack_cnt - acks0, 0);
        single_txn("post_abort", 8'h5A, 8'h00, 1'b0, 8'h5A, 8'hFF);

        // Reset mid-byte
        tx_q.push_back(8'h0F);
        wait_clks(2);
        cs_low();
        spi_bits(8'hF0, 3, mi);
        rst_n = 1'b0;
        wait_clks(1);
        $display("txn reset: rst_n pulsed after 3 bits");
        check("midrst_miso", spi_miso, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_data_rx", data_rx, 8'h00);
        check("midrst_rx_valid", rx_valid, 1'b0);
        check("midrst_tx_ack", tx_ack, 1'b0);
        spi_cs_n = 1'b1;
        spi_clk  = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(4);
        tx_q.delete();
        wait_clks(2);
        single_txn("post_reset", 8'h96, 8'h69, 1'b1, 8'h96, 8'h69);

        // Minimum spi_clk half-period, plus clk activity while deselected
        half = SYNC_STAGES + 2;
        acks0 = ack_cnt;
        rx0   = idle_viol;
        rx_q.delete();
        for (int i = 0; i < 4; i++) begin
            spi_clk = 1'b1;
            wait_clks(half);
            spi_clk = 1'b0;
            wait_clks(half);
        end
        $display("txn idle_clk: 4 spi_clk pulses with cs_n high");
        check("idleclk_busy", busy, 1'b0);
        check("idleclk_rx", rx_q.size(), 0);
        check("idleclk_acks", ack_cnt - acks0, 0);
        check("idleclk_miso", spi_miso, 1'b0);
        single_txn("fast", 8'h3C, 8'hA5, 1'b1, 8'h3C, 8'hA5);

        check("idle_pulses", idle_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
